// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) helpers for the decryption datapath.
// Column c of a state lives at bits [127-32c -: 32], with row 0 in the column MSB.
package aes_pkg;

  typedef logic [127:0] state_t;
  typedef logic [31:0]  col_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } fsm_t;

  function automatic col_t get_col(input state_t s, input logic [1:0] idx);
    col_t c;
    case (idx)
      2'd0:    c = s[127:96];
      2'd1:    c = s[95:64];
      2'd2:    c = s[63:32];
      default: c = s[31:0];
    endcase
    return c;
  endfunction

  function automatic state_t set_col(input state_t s, input logic [1:0] idx, input col_t c);
    state_t r;
    r = s;
    case (idx)
      2'd0:    r[127:96] = c;
      2'd1:    r[95:64]  = c;
      2'd2:    r[63:32]  = c;
      default: r[31:0]   = c;
    endcase
    return r;
  endfunction

  // Multiply by x modulo x^8 + x^4 + x^3 + x + 1 (0x11B).
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] multiply9(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ a;
  endfunction

  function automatic logic [7:0] multiplyB(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
  endfunction

  function automatic logic [7:0] multiplyD(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
  endfunction

  function automatic logic [7:0] multiplyE(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
  endfunction

endpackage

// File: rtl/inv_mix_column.sv
// Combinational InvMixColumns on one 32-bit column using the matrix
// [E B D 9; 9 E B D; D 9 E B; B D 9 E].
module inv_mix_column
  import aes_pkg::*;
(
  input  col_t col,
  output col_t res
);

  logic [7:0] a0, a1, a2, a3;
  logic [7:0] b0, b1, b2, b3;

  assign a0 = col[31:24];
  assign a1 = col[23:16];
  assign a2 = col[15:8];
  assign a3 = col[7:0];

  assign b0 = multiplyE(a0) ^ multiplyB(a1) ^ multiplyD(a2) ^ multiply9(a3);
  assign b1 = multiply9(a0) ^ multiplyE(a1) ^ multiplyB(a2) ^ multiplyD(a3);
  assign b2 = multiplyD(a0) ^ multiply9(a1) ^ multiplyE(a2) ^ multiplyB(a3);
  assign b3 = multiplyB(a0) ^ multiplyD(a1) ^ multiply9(a2) ^ multiplyE(a3);

  assign res = {b0, b1, b2, b3};

endmodule

// File: rtl/inv_mix_columns_seq.sv
// Sequential InvMixColumns: captures a state, rewrites COLS_PER_CYCLE columns of the
// work register per CALC cycle, then holds the result until downstream takes it.
module inv_mix_columns_seq
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_bypass,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  localparam int CALC_CYCLES = 4 / COLS_PER_CYCLE;

  if (COLS_PER_CYCLE < 1 || COLS_PER_CYCLE > 4 || CALC_CYCLES * COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("inv_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  fsm_t       state, state_nxt;
  logic [1:0] col_idx;
  state_t     work, work_nxt;
  logic       bypass;
  logic       last_group;
  col_t       col_src [COLS_PER_CYCLE];
  col_t       col_mix [COLS_PER_CYCLE];

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // ready/valid here decode from registered state only, never from the partner's signal.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_data  = work;

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
    assign col_src[g] = get_col(work, col_idx + 2'(g));
    inv_mix_column u_imc (
      .col (col_src[g]),
      .res (col_mix[g])
    );
  end

  // Groups are aligned, so the group that holds column 3 is always the last one.
  assign last_group = ((col_idx + 2'(COLS_PER_CYCLE - 1)) == 2'd3);

  always_comb begin
    work_nxt = work;
    for (int g = 0; g < COLS_PER_CYCLE; g++) begin
      work_nxt = set_col(work_nxt, col_idx + 2'(g), bypass ? col_src[g] : col_mix[g]);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)   state_nxt = CALC;
      CALC:    if (last_group) state_nxt = DONE;
      DONE:    if (out_ready)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      col_idx <= 2'd0;
      work    <= '0;
      bypass  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_valid) begin
            work    <= in_data;
            bypass  <= in_bypass;
            col_idx <= 2'd0;
          end
        end
        CALC: begin
          work    <= work_nxt;
          col_idx <= col_idx + 2'(COLS_PER_CYCLE);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Scoreboard bench for inv_mix_columns_seq: directed FIPS-197 columns plus random blocks.
module tb_inv_mix_columns_seq;

  localparam int CPC         = 1;
  localparam int CALC_CYCLES = 4 / CPC;
  localparam int W           = 128;

  localparam logic [W-1:0] V1 = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [W-1:0] E1 = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [W-1:0] V2 = 128'hd5d5d7d6_d5d5d7d6_d5d5d7d6_d5d5d7d6;
  localparam logic [W-1:0] E2 = 128'hd4d4d4d5_d4d4d4d5_d4d4d4d5_d4d4d4d5;
  localparam logic [W-1:0] V3 = 128'h4d7ebdf8_d5d5d7d6_9fdc589d_c6c6c6c6;
  localparam logic [W-1:0] E3 = 128'h2d26314c_d4d4d4d5_f20a225c_c6c6c6c6;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         in_bypass = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;

  logic [W-1:0] exp_q[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  bit           rand_ready = 1'b0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  inv_mix_columns_seq #(.COLS_PER_CYCLE(CPC)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_bypass (in_bypass),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [W-1:0] model(input logic [W-1:0] s, input logic byp);
    logic [W-1:0] r;
    logic [31:0]  col;
    logic [7:0]   a [4];
    logic [7:0]   k [4];
    logic [7:0]   b;
    if (byp) return s;
    k[0] = 8'h0e; k[1] = 8'h0b; k[2] = 8'h0d; k[3] = 8'h09;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      col = s[127-32*c -: 32];
      for (int j = 0; j < 4; j++) a[j] = col[31-8*j -: 8];
      for (int rr = 0; rr < 4; rr++) begin
        b = 8'h00;
        for (int j = 0; j < 4; j++) b = b ^ gmul(k[(j - rr) & 3], a[j]);
        r[127-32*c-8*rr -: 8] = b;
      end
    end
    return r;
  endfunction

  // ---------------- check helpers ----------------
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input logic [W-1:0] d, input logic byp, input logic [W-1:0] expv);
    in_data   = d;
    in_bypass = byp;
    in_valid  = 1'b1;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(expv);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    n_cmp++;
    n_bad++;
    $display("FAIL send_timeout: in_ready never rose for %h", d);
    in_valid = 1'b0;
  endtask

  // Called right after the accept edge; counts edges until one samples out_valid high.
  task automatic measure_latency(input string name);
    int  n;
    bit  seen;
    n    = 0;
    seen = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      n++;
    end
    if (!seen) n = -1;
    check(name, W'(n + 1), W'(CALC_CYCLES + 1));
  endtask

  task automatic drain(input int budget);
    bit done;
    done = 1'b0;
    for (int t = 0; t < budget; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d results still pending", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output: got %h required none", out_data);
      end else begin
        check("out_data", out_data, exp_q.pop_front());
      end
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] d;
    logic         byp;

    #1;
    check("reset_in_ready", W'(in_ready), W'(1));
    check("reset_out_valid", W'(out_valid), W'(0));
    check("reset_out_data", out_data, '0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Known vector, checking latency.
    out_ready = 1'b1;
    send(V1, 1'b0, E1);
    measure_latency("latency_mix");
    drain(50);

    // Bypass: identity, same latency.
    send(V1, 1'b1, V1);
    measure_latency("latency_bypass");
    drain(50);

    // Backpressure with a second block waiting.
    out_ready = 1'b0;
    send(V1, 1'b0, E1);
    in_data   = V2;
    in_bypass = 1'b0;
    in_valid  = 1'b1;
    for (int t = 0; t < 50 && !out_valid; t++) @(negedge clk);
    check("bp_out_valid_rise", W'(out_valid), W'(1));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hold_data", out_data, E1);
      check("bp_in_ready_low", W'(in_ready), W'(0));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(V2, 1'b0, E2);
    drain(50);

    // Inputs change after acceptance.
    send(V3, 1'b0, E3);
    for (int i = 0; i < 8; i++) begin
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      in_bypass = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    drain(50);

    // Asynchronous reset in the middle of CALC, at col_idx = 2.
    send(V1, 1'b0, E1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    #2;
    rst = 1'b1;
    void'(exp_q.pop_back());
    #1;
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_out_data", out_data, '0);
    check("rst_in_ready", W'(in_ready), W'(1));
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("rst_no_stale_valid", W'(out_valid), W'(0));
    end
    @(posedge clk);
    #1;
    send(V3, 1'b0, E3);
    drain(50);

    // Random blocks with random gaps and backpressure.
    rand_ready = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      d   = {$urandom, $urandom, $urandom, $urandom};
      byp = ($urandom_range(0, 7) == 0);
      send(d, byp, model(d, byp));
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    drain(200);
    check("queue_empty", W'(exp_q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
